// File: rtl/rib_mem_responder_pkg.sv
// Shared types and constants for the RIB memory responder and its SRAM.
package rib_mem_responder_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam logic [MEM_DATA_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RESP_IDLE   = 2'd0,
    RESP_ACCESS = 2'd1,
    RESP_DONE   = 2'd2
  } resp_state_e;

  // Data-port request captured when IDLE accepts it, so a dropped req mid-access still completes.
  typedef struct packed {
    logic                  hit;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
  } ex_req_t;

  function automatic logic region_hit(input logic [3:0] region, input logic [3:0] base);
    return region == base;
  endfunction

endpackage

// File: rtl/rib_sram_1p.sv
// Single-port synchronous RAM with registered read, no reset (block-RAM inferable).
module rib_sram_1p #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/rib_mem_responder.sv
// RIB responder: serves the core's data and fetch ports from one single-port SRAM,
// data port first, stalling the core while a data access owns the array.
module rib_mem_responder
  import rib_mem_responder_pkg::*;
#(
  parameter int          DEPTH    = 4096,
  parameter int          AW       = 12,
  parameter logic [3:0]  BASE     = 4'h0,
  parameter logic [31:0] NOP_INST = INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_data_i,
  input  logic        ex_req_i,
  input  logic        ex_we_i,
  output logic [31:0] ex_data_o,
  input  logic [31:0] pc_addr_i,
  output logic [31:0] pc_data_o,
  output logic        hold_flag_o,
  output logic        addr_err_o
);

  resp_state_e state, state_nxt;
  ex_req_t     req_q;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] ex_idx, pc_idx;

  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;

  logic        fetch_rd, fetch_vld;
  logic        rd_hit;
  logic [31:0] pc_q, ex_q, done_data;

  logic unused_addr_bits;

  assign ex_idx = ex_addr_i[AW+1:2];
  assign pc_idx = pc_addr_i[AW+1:2];
  assign unused_addr_bits = ^{ex_addr_i[27:AW+2], ex_addr_i[1:0],
                              pc_addr_i[31:AW+2], pc_addr_i[1:0]};

  rib_sram_1p #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (MEM_DATA_W)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (req_q.wdata),
    .rdata (sram_rdata)
  );

  always_comb begin
    state_nxt   = state;
    hold_flag_o = 1'b0;
    sram_en     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = pc_idx;
    fetch_rd    = 1'b0;
    case (state)
      RESP_IDLE: begin
        if (ex_req_i) begin
          hold_flag_o = 1'b1;
          sram_addr   = ex_idx;
          state_nxt   = RESP_ACCESS;
        end else begin
          sram_en  = 1'b1;
          fetch_rd = 1'b1;
        end
      end
      RESP_ACCESS: begin
        hold_flag_o = 1'b1;
        sram_addr   = req_idx;
        sram_en     = req_q.hit;
        // a reset on the closing edge discards the write
        sram_we     = req_q.hit & req_q.we & ~rst;
        state_nxt   = RESP_DONE;
      end
      RESP_DONE: begin
        sram_en   = 1'b1;
        fetch_rd  = 1'b1;
        state_nxt = RESP_IDLE;
      end
      default: state_nxt = RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESP_IDLE;
      fetch_vld <= 1'b0;
      rd_hit    <= 1'b0;
      pc_q      <= NOP_INST;
      ex_q      <= '0;
      req_q     <= '0;
      req_idx   <= '0;
    end else begin
      state     <= state_nxt;
      fetch_vld <= fetch_rd;
      if (fetch_vld) pc_q <= sram_rdata;
      if (state == RESP_IDLE && ex_req_i) begin
        req_q.hit   <= region_hit(ex_addr_i[31:28], BASE);
        req_q.we    <= ex_we_i;
        req_q.wdata <= ex_data_i;
        req_idx     <= ex_idx;
      end
      if (state == RESP_ACCESS) rd_hit <= req_q.hit & ~req_q.we;
      if (state == RESP_DONE)   ex_q   <= done_data;
    end
  end

  // SRAM output is the fetch/read data register; the hold registers keep it stable
  // across cycles where the array is busy with the other port.
  assign done_data   = rd_hit ? sram_rdata : '0;
  assign ex_data_o   = (state == RESP_DONE) ? done_data : ex_q;
  assign pc_data_o   = fetch_vld ? sram_rdata : pc_q;
  assign addr_err_o  = (state == RESP_ACCESS) & ~req_q.hit;

endmodule
